// File: rtl/pulse_capture_seq_if.sv
// Bus between the trigger/config sources, the pulse sequencer and the SPRAM capture port.
// Direction contract: the master drives trig/abort/pulse_en/clr_flags/cfg_*; the slave
// (the sequencer) drives the capture and pulse outputs. There is no ready: trig is a
// level request sampled every cycle and either starts a shot or is counted as an overrun.
interface pulse_capture_seq_if #(
   parameter int ADDR_W = 13,
   parameter int CFG_W  = 8
);
   logic              trig;
   logic              abort;
   logic              pulse_en;
   logic              clr_flags;
   logic [CFG_W-1:0]  cfg_pre;
   logic [CFG_W-1:0]  cfg_phv;
   logic [CFG_W-1:0]  cfg_gap1;
   logic [CFG_W-1:0]  cfg_pnhv;
   logic [CFG_W-1:0]  cfg_gap2;
   logic [CFG_W-1:0]  cfg_damp;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              PHV;
   logic              PnHV;
   logic              Pdamp;
   logic              busy;
   logic              done;
   logic              overrun;
   logic              aborted;

   modport master (
      output trig, abort, pulse_en, clr_flags,
      output cfg_pre, cfg_phv, cfg_gap1, cfg_pnhv, cfg_gap2, cfg_damp,
      input  wr_en, wr_addr, PHV, PnHV, Pdamp, busy, done, overrun, aborted
   );

   modport slave (
      input  trig, abort, pulse_en, clr_flags,
      input  cfg_pre, cfg_phv, cfg_gap1, cfg_pnhv, cfg_gap2, cfg_damp,
      output wr_en, wr_addr, PHV, PnHV, Pdamp, busy, done, overrun, aborted
   );
endinterface

// File: rtl/pulse_capture_seq.sv
// Pulser and acquisition sequencer: a trigger opens a 2^ADDR_W sample capture window
// and, inside it, plays PHV -> PnHV -> Pdamp with per-shot latched timing.
// The pulse FSM state always describes the sample at the current wr_addr, so every
// output register is loaded from the next-state value and stays address-aligned.
module pulse_capture_seq #(
   parameter int ADDR_W = 13,
   parameter int CFG_W  = 8
) (
   input  logic               DCLK,
   input  logic               rst,
   pulse_capture_seq_if.slave bus,
   output logic [2:0]         dbg_state_o
);

   localparam int NPH = 6;
   localparam int LW  = NPH * CFG_W;

   // Encoding order matters: timed phases 1..6 index their field in the packed config.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_PHV  = 3'd2,
      S_GAP1 = 3'd3,
      S_PNHV = 3'd4,
      S_GAP2 = 3'd5,
      S_DAMP = 3'd6,
      S_TAIL = 3'd7
   } state_t;

   typedef struct packed {
      state_t           st;
      logic [CFG_W-1:0] len;
   } step_t;

   state_t            state_q, state_d;
   logic [CFG_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic              done_q, done_d;
   logic              phv_q, phv_d;
   logic              pnhv_q, pnhv_d;
   logic              damp_q, damp_d;
   logic              ovr_q, ovr_d;
   logic              abt_q, abt_d;
   logic [LW-1:0]     cfg_q, cfg_d;
   logic [LW-1:0]     cfg_in;
   step_t             start_step;
   step_t             next_step;

   // First phase at or after 'from' with a nonzero length; zero-length phases cost no cycle.
   function automatic step_t seek(input logic [2:0] from, input logic [LW-1:0] lens);
      step_t r;
      logic  found;
      r     = '0;
      r.st  = S_TAIL;
      found = 1'b0;
      for (int k = 1; k <= NPH; k++) begin
         if (!found && (k >= int'(from)) && (lens[(k-1)*CFG_W +: CFG_W] != '0)) begin
            r.st  = state_t'(k[2:0]);
            r.len = lens[(k-1)*CFG_W +: CFG_W];
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign cfg_in     = {bus.cfg_damp, bus.cfg_gap2, bus.cfg_pnhv,
                        bus.cfg_gap1, bus.cfg_phv, bus.cfg_pre};
   assign start_step = seek(3'd1, cfg_in);
   assign next_step  = seek(3'(state_q) + 3'd1, cfg_q);

   // Next-state: shot start/stop, address sequencing, phase advance and sticky flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_en_d = wr_en_q;
      done_d  = 1'b0;
      cfg_d   = cfg_q;
      ovr_d   = ovr_q;
      abt_d   = abt_q;
      // Clear first so a same-cycle set event below overrides it.
      if (bus.clr_flags) begin
         ovr_d = 1'b0;
         abt_d = 1'b0;
      end
      if (!wr_en_q) begin
         state_d = S_IDLE;
         addr_d  = '1;
         cnt_d   = '0;
         // abort in the same idle cycle drops the trigger without flagging anything.
         if (bus.trig && !bus.abort) begin
            wr_en_d = 1'b1;
            addr_d  = '0;
            cfg_d   = cfg_in;
            state_d = start_step.st;
            cnt_d   = start_step.len;
         end
      end else begin
         if (bus.trig) ovr_d = 1'b1;
         if (bus.abort) begin
            wr_en_d = 1'b0;
            addr_d  = '1;
            state_d = S_IDLE;
            cnt_d   = '0;
            abt_d   = 1'b1;
         end else if (addr_q == '1) begin
            // Window end truncates whatever pulse phase is still running.
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            addr_d  = '1;
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (state_q != S_TAIL) begin
               if (cnt_q == CFG_W'(1)) begin
                  state_d = next_step.st;
                  cnt_d   = next_step.len;
               end else begin
                  cnt_d = cnt_q - CFG_W'(1);
               end
            end
         end
      end
      // pulse_en gates only the lines; the FSM keeps its timing underneath.
      phv_d  = bus.pulse_en && (state_d == S_PHV);
      pnhv_d = bus.pulse_en && (state_d == S_PNHV);
      damp_d = bus.pulse_en && (state_d == S_DAMP);
   end

   // State and registered outputs; rst overrides everything.
   always_ff @(posedge DCLK) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '1;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         phv_q   <= 1'b0;
         pnhv_q  <= 1'b0;
         damp_q  <= 1'b0;
         ovr_q   <= 1'b0;
         abt_q   <= 1'b0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_en_q <= wr_en_d;
         done_q  <= done_d;
         phv_q   <= phv_d;
         pnhv_q  <= pnhv_d;
         damp_q  <= damp_d;
         ovr_q   <= ovr_d;
         abt_q   <= abt_d;
         cfg_q   <= cfg_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.busy    = wr_en_q;
   assign bus.wr_addr = addr_q;
   assign bus.PHV     = phv_q;
   assign bus.PnHV    = pnhv_q;
   assign bus.Pdamp   = damp_q;
   assign bus.done    = done_q;
   assign bus.overrun = ovr_q;
   assign bus.aborted = abt_q;
   assign dbg_state_o = 3'(state_q);

endmodule

// File: tb/tb_pulse_capture_seq.sv
// Bench for pulse_capture_seq: a full-size instance (13-bit window) for the timing
// tables and directed corner cases, and a 32-sample instance for window truncation
// and randomized traffic. A cycle model built from the address-range rules checks
// the selected instance on every cycle.
module tb_pulse_capture_seq;
   localparam int CW = 8;

   // ---------------- clock / reset ----------------
   logic DCLK = 1'b0;
   logic rst;
   always #8 DCLK = ~DCLK;

   logic          trig, abort, pen, clr;
   logic [CW-1:0] c_pre, c_phv, c_gap1, c_pnhv, c_gap2, c_damp;
   bit            sel;   // 0: full-size instance under test, 1: small instance
   logic [2:0]    bdbg, sdbg;

   pulse_capture_seq_if #(.ADDR_W(13), .CFG_W(CW)) bif ();
   pulse_capture_seq_if #(.ADDR_W(5),  .CFG_W(CW)) sif ();

   assign bif.trig      = sel ? 1'b0 : trig;
   assign bif.abort     = sel ? 1'b0 : abort;
   assign bif.clr_flags = sel ? 1'b0 : clr;
   assign bif.pulse_en  = pen;
   assign sif.trig      = sel ? trig  : 1'b0;
   assign sif.abort     = sel ? abort : 1'b0;
   assign sif.clr_flags = sel ? clr   : 1'b0;
   assign sif.pulse_en  = pen;
   assign bif.cfg_pre = c_pre;   assign sif.cfg_pre = c_pre;
   assign bif.cfg_phv = c_phv;   assign sif.cfg_phv = c_phv;
   assign bif.cfg_gap1 = c_gap1; assign sif.cfg_gap1 = c_gap1;
   assign bif.cfg_pnhv = c_pnhv; assign sif.cfg_pnhv = c_pnhv;
   assign bif.cfg_gap2 = c_gap2; assign sif.cfg_gap2 = c_gap2;
   assign bif.cfg_damp = c_damp; assign sif.cfg_damp = c_damp;

   pulse_capture_seq #(.ADDR_W(13), .CFG_W(CW)) u_dut (
      .DCLK(DCLK), .rst(rst), .bus(bif), .dbg_state_o(bdbg)
   );
   pulse_capture_seq #(.ADDR_W(5), .CFG_W(CW)) u_small (
      .DCLK(DCLK), .rst(rst), .bus(sif), .dbg_state_o(sdbg)
   );

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic we, input logic [12:0] a, input logic ph,
                                        input logic pn, input logic dm, input logic bz,
                                        input logic dn, input logic ov, input logic ab);
      return {11'b0, we, a, ph, pn, dm, bz, dn, ov, ab};
   endfunction

   function automatic logic [31:0] big_act();
      return pack(bif.wr_en, bif.wr_addr, bif.PHV, bif.PnHV, bif.Pdamp,
                  bif.busy, bif.done, bif.overrun, bif.aborted);
   endfunction

   function automatic logic [31:0] small_act();
      return pack(sif.wr_en, 13'(sif.wr_addr), sif.PHV, sif.PnHV, sif.Pdamp,
                  sif.busy, sif.done, sif.overrun, sif.aborted);
   endfunction

   // ---------------- reference model ----------------
   // Shot-level model: a window is busy for addresses 0..win-1; each pulse line is high
   // exactly when the current address falls in its interval derived from the cfg sums.
   bit m_busy, m_done, m_ovr, m_abt, m_pen;
   int m_addr;
   int m_cfg[6];

   function automatic int win_len();
      return sel ? 32 : 8192;
   endfunction

   task automatic model_step();
      bit nd, s_ovr, s_abt;
      nd = 1'b0; s_ovr = 1'b0; s_abt = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_addr = 0; m_done = 1'b0; m_ovr = 1'b0; m_abt = 1'b0; m_pen = 1'b0;
      end else begin
         if (!m_busy) begin
            if (trig && !abort) begin
               m_busy = 1'b1; m_addr = 0;
               m_cfg[0] = int'(c_pre);  m_cfg[1] = int'(c_phv);  m_cfg[2] = int'(c_gap1);
               m_cfg[3] = int'(c_pnhv); m_cfg[4] = int'(c_gap2); m_cfg[5] = int'(c_damp);
            end
         end else begin
            if (trig) s_ovr = 1'b1;
            if (abort) begin
               m_busy = 1'b0; s_abt = 1'b1;
            end else if (m_addr == win_len() - 1) begin
               m_busy = 1'b0; nd = 1'b1;
            end else begin
               m_addr++;
            end
         end
         m_done = nd;
         if (clr) begin m_ovr = 1'b0; m_abt = 1'b0; end
         if (s_ovr) m_ovr = 1'b1;
         if (s_abt) m_abt = 1'b1;
         m_pen = pen;
      end
   endtask

   function automatic logic [31:0] exp_vec();
      int  a, e1, s2, e2, s3, e3;
      bit  on, ph, pn, dm;
      a  = m_addr;
      on = m_busy && m_pen;
      e1 = m_cfg[0] + m_cfg[1];
      s2 = e1 + m_cfg[2];
      e2 = s2 + m_cfg[3];
      s3 = e2 + m_cfg[4];
      e3 = s3 + m_cfg[5];
      ph = on && (a >= m_cfg[0]) && (a < e1);
      pn = on && (a >= s2) && (a < e2);
      dm = on && (a >= s3) && (a < e3);
      return pack(m_busy, m_busy ? 13'(a) : 13'(win_len() - 1), ph, pn, dm,
                  m_busy, m_done, m_ovr, m_abt);
   endfunction

   // ---------------- driver ----------------
   // One clock: model consumes the inputs seen at the edge, outputs are compared 1 later.
   task automatic tick();
      @(posedge DCLK);
      model_step();
      #1;
      check("cycle", sel ? small_act() : big_act(), exp_vec());
   endtask

   task automatic set_cfg(input int p, input int h, input int g1, input int pn,
                          input int g2, input int d);
      c_pre = CW'(p); c_phv = CW'(h); c_gap1 = CW'(g1);
      c_pnhv = CW'(pn); c_gap2 = CW'(g2); c_damp = CW'(d);
   endtask

   task automatic scramble_cfg();
      set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   // ---------------- timing table ----------------
   typedef struct {
      int pre, phv, gap1, pnhv, gap2, damp;
      bit pen;
      int phv_lo, phv_hi, pnhv_lo, pnhv_hi, damp_lo, damp_hi;
   } vec_t;

   localparam int NV = 6;
   vec_t vec[NV];

   initial begin
      int  phv_lo, phv_hi, pnhv_lo, pnhv_hi, damp_lo, damp_hi;
      int  wr_n, done_at, a, dones, last_addr;
      bit  got_done;
      logic [31:0] rst_vec;

      vec[0] = '{32, 8, 8, 8, 8, 64, 1'b1, 32, 39, 48, 55, 64, 127};
      vec[1] = '{32, 0, 8, 4, 8, 64, 1'b1, -1, -1, 40, 43, 52, 115};
      vec[2] = '{32, 8, 8, 8, 8, 64, 1'b0, -1, -1, -1, -1, -1, -1};
      vec[3] = '{0, 0, 0, 0, 0, 0, 1'b1, -1, -1, -1, -1, -1, -1};
      vec[4] = '{0, 1, 0, 1, 0, 1, 1'b1, 0, 0, 1, 1, 2, 2};
      vec[5] = '{255, 255, 255, 255, 255, 255, 1'b1, 255, 509, 765, 1019, 1275, 1529};
      rst_vec = pack(1'b0, 13'h1fff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      rst = 1'b1; trig = 1'b0; abort = 1'b0; pen = 1'b1; clr = 1'b0; sel = 1'b0;
      set_cfg(32, 8, 8, 8, 8, 64);
      m_busy = 1'b0; m_addr = 0; m_done = 1'b0; m_ovr = 1'b0; m_abt = 1'b0; m_pen = 1'b0;
      for (int i = 0; i < 6; i++) m_cfg[i] = 0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_outputs", big_act(), rst_vec);
      check("reset_state", 32'(bdbg), 32'd0);
      tick();

      // ---- table-driven full shots ----
      for (int i = 0; i < NV; i++) begin
         set_cfg(vec[i].pre, vec[i].phv, vec[i].gap1, vec[i].pnhv, vec[i].gap2, vec[i].damp);
         pen = vec[i].pen;
         trig = 1'b1;
         phv_lo = -1; phv_hi = -1; pnhv_lo = -1; pnhv_hi = -1; damp_lo = -1; damp_hi = -1;
         wr_n = 0; done_at = -1;
         for (int k = 1; k <= 9000 && done_at < 0; k++) begin
            tick();
            if (k == 1) begin
               trig = 1'b0;
               check("trig_latency", {bif.wr_en, bif.wr_addr}, {1'b1, 13'd0});
               scramble_cfg();
            end
            a = int'(bif.wr_addr);
            if (bif.wr_en) wr_n++;
            if (bif.PHV)   begin if (phv_lo < 0) phv_lo = a;   phv_hi = a;  end
            if (bif.PnHV)  begin if (pnhv_lo < 0) pnhv_lo = a; pnhv_hi = a; end
            if (bif.Pdamp) begin if (damp_lo < 0) damp_lo = a; damp_hi = a; end
            if (bif.done) done_at = k;
         end
         check($sformatf("v%0d_phv_lo", i),  32'(phv_lo),  32'(vec[i].phv_lo));
         check($sformatf("v%0d_phv_hi", i),  32'(phv_hi),  32'(vec[i].phv_hi));
         check($sformatf("v%0d_pnhv_lo", i), 32'(pnhv_lo), 32'(vec[i].pnhv_lo));
         check($sformatf("v%0d_pnhv_hi", i), 32'(pnhv_hi), 32'(vec[i].pnhv_hi));
         check($sformatf("v%0d_damp_lo", i), 32'(damp_lo), 32'(vec[i].damp_lo));
         check($sformatf("v%0d_damp_hi", i), 32'(damp_hi), 32'(vec[i].damp_hi));
         check($sformatf("v%0d_wr_count", i), 32'(wr_n), 32'd8192);
         check($sformatf("v%0d_done_at", i), 32'(done_at), 32'd8193);
      end
      pen = 1'b1;

      // ---- overrun, clr_flags, back-to-back, rst mid-shot ----
      set_cfg(32, 8, 8, 8, 8, 64);
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (100) tick();
      trig = 1'b1; tick(); trig = 1'b0;
      check("overrun_set", {bif.overrun, bif.wr_en, bif.wr_addr}, {1'b1, 1'b1, 13'd101});
      clr = 1'b1; tick(); clr = 1'b0;
      check("overrun_clr", 32'(bif.overrun), 32'd0);
      got_done = 1'b0; last_addr = -1;
      for (int k = 0; k < 9000 && !got_done; k++) begin
         if (bif.wr_en) last_addr = int'(bif.wr_addr);
         tick();
         got_done = bif.done;
      end
      check("window_end_done", 32'(got_done), 32'd1);
      check("window_last_addr", 32'(last_addr), 32'h1fff);
      trig = 1'b1; tick(); trig = 1'b0;
      check("b2b_start", {bif.wr_en, bif.wr_addr, bif.overrun}, {1'b1, 13'd0, 1'b0});
      repeat (50) tick();
      check("pnhv_at_50", {bif.wr_addr, bif.PnHV}, {13'd50, 1'b1});
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_shot", big_act(), rst_vec);
      check("rst_mid_state", 32'(bdbg), 32'd0);

      // ---- abort handling ----
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (36) tick();
      check("phv_at_36", {bif.wr_addr, bif.PHV}, {13'd36, 1'b1});
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_outputs", big_act(),
            pack(1'b0, 13'h1fff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      check("abort_state", 32'(bdbg), 32'd0);
      dones = 0;
      repeat (20) begin tick(); if (bif.done) dones++; end
      check("abort_no_done", 32'(dones), 32'd0);
      trig = 1'b1; tick(); trig = 1'b0;
      check("restart_after_abort", {bif.wr_en, bif.wr_addr, bif.PHV}, {1'b1, 13'd0, 1'b0});
      abort = 1'b1; clr = 1'b1; tick(); abort = 1'b0; clr = 1'b0;
      check("set_beats_clr", {bif.aborted, bif.wr_en}, {1'b1, 1'b0});
      clr = 1'b1; tick(); clr = 1'b0;
      check("aborted_clr", 32'(bif.aborted), 32'd0);
      abort = 1'b1; trig = 1'b1; tick(); abort = 1'b0; trig = 1'b0;
      check("abort_trig_idle", big_act(), rst_vec);

      // ---- short window truncates the pulse train ----
      sel = 1'b1;
      set_cfg(20, 20, 0, 0, 0, 0);
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (31) tick();
      check("small_phv_last", {sif.wr_addr, sif.PHV}, {5'd31, 1'b1});
      tick();
      check("small_window_end", small_act(),
            pack(1'b0, 13'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      set_cfg(2, 2, 1, 3, 0, 4);
      trig = 1'b1; tick(); trig = 1'b0;
      repeat (2) tick();
      check("small_next_shot", {sif.wr_addr, sif.PHV}, {5'd2, 1'b1});

      // ---- randomized traffic on the small window ----
      for (int c = 0; c < 4000; c++) begin
         trig  = ($urandom_range(0, 15) == 0);
         abort = ($urandom_range(0, 99) == 0);
         clr   = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 29) == 0) pen = ~pen;
         if ($urandom_range(0, 7) == 0)
            set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         tick();
      end
      trig = 1'b0; abort = 1'b0; clr = 1'b0; rst = 1'b0; pen = 1'b1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
